// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, register-index width and the x0 register index.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the EX load and the ID instruction.
// Writes to x0 never create a hazard because x0 is never written.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    assign load_use = ex_memread && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze and timeout fault.
// Define PIPE_PERF_CNT_EN to build the saturating stall_cycles / flush_count performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 pipe_freeze,
    output logic                 fault,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_e       state;
    pipe_state_e       state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              load_use;
    logic              mem_stall;

    load_use_detect u_load_use_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    assign mem_stall = mem_req && !mem_ready && ((state == RUN) || (state == MEM_WAIT));
    assign fault     = (state == FAULT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // wait_cnt counts completed MEM_WAIT cycles; the last allowed one escalates to FAULT.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next    = FAULT;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // A taken branch squashes the ID instruction, so its load-use hazard is moot.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (!reset) begin
            if ((state == FAULT) || mem_stall) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_freeze = 1'b1;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stall_event;
    logic flush_event;

    assign stall_event = pipe_freeze || (id_ex_bubble && !if_id_flush);
    assign flush_event = if_id_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_event && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_event && !(&flush_count)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
